// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the data memory loader.
package mem_loader_pkg;

    localparam int unsigned DEF_ADDR_W    = 12;
    localparam int unsigned DEF_MAX_WORDS = 1024;
    localparam logic [3:0]  WR_ALL        = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        WRITE,
        FINISH
    } state_e;

endpackage

// File: rtl/data_mem_loader.sv
// Pairs host words and writes them to the data memory two at a time via dual-slot init mode.
// Optional feature: DATA_MEM_LOADER_CHECKSUM_EN enables the running checksum of accepted words.
module data_mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [10:0]       word_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    input  logic              enable_halt,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_Datain1,
    output logic [31:0]       mem_Datain2,
    output logic [3:0]        mem_Wr,
    output logic              mem_enable_load,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [10:0]       rem_q, rem_d;
    logic [31:0]       d1_q, d1_d;
    logic [31:0]       d2_q, d2_d;
    logic [3:0]        wr_q, wr_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic        hs;
    logic        range_bad;
    logic        start_ok;
    logic [31:0] end_addr;

    assign s_ready   = (state_q == FILL0) || (state_q == FILL1);
    assign hs        = s_valid && s_ready;
    assign end_addr  = 32'(base_addr) + (32'(word_count) << 2);
    assign range_bad = (base_addr[1:0] != 2'b00) || (end_addr > (32'(MAX_WORDS) << 2));
    assign start_ok  = (state_q == IDLE) && start && !range_bad;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        wr_d    = wr_q;
        load_d  = load_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        error_d = 1'b1;
                    end else if (word_count == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = word_count;
                        state_d = FILL0;
                    end
                end
            end
            FILL0: begin
                if (hs) begin
                    d1_d  = s_data;
                    rem_d = rem_q - 11'd1;
                    if (rem_q == 11'd1) begin
                        wr_d    = WR_ALL;
                        load_d  = 1'b0;
                        state_d = WRITE;
                    end else begin
                        state_d = FILL1;
                    end
                end
            end
            FILL1: begin
                if (hs) begin
                    d2_d    = s_data;
                    rem_d   = rem_q - 11'd1;
                    wr_d    = WR_ALL;
                    load_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // load_q doubles as the pair flag: it is only set for a full pair
                if (!enable_halt) begin
                    addr_d = addr_q + (load_q ? ADDR_W'(8) : ADDR_W'(4));
                    wr_d   = '0;
                    load_d = 1'b0;
                    if (rem_q == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL0;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            wr_q    <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign mem_address     = addr_q;
    assign mem_Datain1     = d1_q;
    assign mem_Datain2     = d2_q;
    assign mem_Wr          = wr_q;
    assign mem_enable_load = load_q;
    assign done            = done_q;
    assign error           = error_q;

`ifdef DATA_MEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (hs) begin
            sum_d = sum_q + s_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign checksum        = '0;
`endif

endmodule

// File: tb/tb_data_mem_loader.sv
// Randomized bench for data_mem_loader against a word-array memory image model.
// Build with DATA_MEM_LOADER_CHECKSUM_EN to also check the checksum feature.
module tb_data_mem_loader;
    import mem_loader_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned MW = 1024;

    logic          Clk, Rst_n, start, s_valid, s_ready, enable_halt;
    logic [AW-1:0] base_addr, mem_address;
    logic [10:0]   word_count;
    logic [31:0]   s_data, mem_Datain1, mem_Datain2, checksum;
    logic [3:0]    mem_Wr;
    logic          mem_enable_load, busy, done, error;

    data_mem_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .enable_halt(enable_halt), .mem_address(mem_address),
        .mem_Datain1(mem_Datain1), .mem_Datain2(mem_Datain2), .mem_Wr(mem_Wr),
        .mem_enable_load(mem_enable_load), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0]   mem     [MW];
    logic [31:0]   exp_mem [MW];
    logic [31:0]   words   [$];
    logic [AW:0]   wlog    [$];
    logic [31:0]   last_sum;
    int unsigned   n_checks, n_pass;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_checksum();
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
        return last_sum;
`else
        return 32'h0;
`endif
    endfunction

    // Data memory behaviour for the edge that follows the current negedge.
    task automatic apply_mem_write();
        int unsigned i;
        if (!Rst_n || enable_halt) return;
        i = int'(mem_address[AW-1:2]);
        if (mem_enable_load) mem[(i + 1) % MW] = mem_Datain2;
        for (int b = 0; b < 4; b++)
            if (mem_Wr[b]) mem[i][8*b +: 8] = mem_Datain1[8*b +: 8];
        if (mem_Wr != 4'h0 || mem_enable_load) wlog.push_back({mem_enable_load, mem_address});
    endtask

    task automatic compare_mem(input string tag);
        int unsigned bad = 0;
        for (int i = 0; i < int'(MW); i++) if (mem[i] !== exp_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random
    task automatic run_load(input string name, input logic [AW-1:0] base, input int unsigned cnt,
                            input int vmode, input bit halt_rand, input bit halt_freeze,
                            input bit chk_latency);
        bit          ok;
        int unsigned idx = 0, dones = 0, errs = 0, nexp;
        bit          busy_seen = 0, in_freeze = 0, froze = 0, rel_chk = 0;
        int          hl = 0, first_hs = -1, done_cyc = -1;
        logic [95:0] snap, outs;
        logic [31:0] sum = 0;

        ok = (base[1:0] == 2'b00) && (int'(base) + 4 * int'(cnt) <= 4 * int'(MW));
        wlog.delete();
        @(negedge Clk);
        base_addr = base; word_count = 11'(cnt); start = 1'b1;
        s_valid = 1'b0; enable_halt = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            outs = {13'h0, busy, s_ready, mem_address, mem_Datain1, mem_Datain2, mem_Wr, mem_enable_load};
            if (done) begin dones++; done_cyc = cyc; end
            if (error) errs++;
            if (busy) busy_seen = 1;
            if (rel_chk) begin check({name, ":halt_release"}, mem_Wr, 4'h0); rel_chk = 0; end
            if (in_freeze) begin
                check({name, ":halt_freeze"}, outs, snap);
                if (hl == 0) begin in_freeze = 0; rel_chk = 1; end
            end
            if (halt_freeze && !froze && mem_Wr != 4'h0) begin
                froze = 1; in_freeze = 1; hl = 5; snap = outs;
            end
            if ((ok && dones > 0) || (!ok && cyc >= 4)) break;
            s_valid = (idx < cnt) && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                                      (vmode == 2 && $urandom_range(0, 1) == 1));
            s_data  = s_valid ? words[idx] : $urandom;
            if (hl > 0) begin enable_halt = 1'b1; hl--; end
            else enable_halt = halt_rand && ($urandom_range(0, 3) == 0);
            if (s_valid && s_ready) begin
                if (first_hs < 0) first_hs = cyc;
                idx++;
            end
            apply_mem_write();
            @(negedge Clk);
        end
        s_valid = 1'b0; enable_halt = 1'b0;

        check({name, ":error"}, errs, ok ? 0 : 1);
        check({name, ":done"}, dones, ok ? 1 : 0);
        check({name, ":accepted"}, idx, ok ? cnt : 0);
        if (!ok) check({name, ":busy_idle"}, busy_seen, 0);
        nexp = ok ? (cnt + 1) / 2 : 0;
        check({name, ":n_writes"}, wlog.size(), nexp);
        for (int i = 0; i < int'(nexp) && i < wlog.size(); i++)
            check({name, ":write"}, wlog[i],
                  {(2 * i + 1 < int'(cnt)) ? 1'b1 : 1'b0, AW'(int'(base) + 8 * i)});
        if (ok) begin
            for (int i = 0; i < int'(cnt); i++) begin
                exp_mem[(int'(base) / 4) + i] = words[i];
                sum += words[i];
            end
            last_sum = sum;
        end
        compare_mem({name, ":mem"});
        check({name, ":checksum"}, checksum, exp_checksum());
        if (chk_latency) check({name, ":done_cycle"}, done_cyc - first_hs + 1, 7);
    endtask

    task automatic rand_words(input int unsigned n);
        words.delete();
        for (int i = 0; i < int'(n); i++) words.push_back($urandom);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; last_sum = 0;
        for (int i = 0; i < int'(MW); i++) begin mem[i] = 32'hDEADBEEF; exp_mem[i] = 32'hDEADBEEF; end
        Rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        s_valid = 1'b0; s_data = '0; enable_halt = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_outs", {s_ready, busy, done, error, mem_address, mem_Datain1, mem_Datain2,
                             mem_Wr, mem_enable_load, checksum}, '0);
        Rst_n = 1'b1;

        words = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_load("pairs4", 12'h100, 4, 0, 0, 0, 1);

        rand_words(3);
        run_load("odd3", 12'h200, 3, 0, 0, 0, 0);
        check("odd3:guard", mem[12'h20C / 4], 32'hDEADBEEF);

        rand_words(2);
        run_load("misalign", 12'h002, 1, 0, 0, 0, 0);
        run_load("overrun", 12'hFFC, 2, 0, 0, 0, 0);
        run_load("top_fit", 12'hFF8, 2, 0, 0, 0, 0);
        run_load("zero", 12'h300, 0, 0, 0, 0, 0);

        rand_words(4);
        run_load("halt5", 12'h400, 4, 0, 0, 1, 0);

        rand_words(6);
        run_load("toggle6", 12'h500, 6, 1, 0, 0, 0);

        // Reset after the first word of a pair
        rand_words(4);
        @(negedge Clk);
        base_addr = 12'h600; word_count = 11'd4; start = 1'b1;
        @(negedge Clk);
        start = 1'b0; s_valid = 1'b1; s_data = words[0];
        check("rst:ready", s_ready, 1'b1);
        @(negedge Clk);
        s_valid = 1'b0;
        check("rst:busy_fill1", busy, 1'b1);
        Rst_n = 1'b0;
        #1;
        check("rst:outs", {s_ready, busy, done, error, mem_address, mem_Datain1, mem_Datain2,
                           mem_Wr, mem_enable_load, checksum}, '0);
        last_sum = 0;
        @(negedge Clk);
        Rst_n = 1'b1;
        compare_mem("rst:mem");
        words = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        run_load("after_rst", 12'h600, 4, 0, 0, 0, 0);
`ifdef DATA_MEM_LOADER_CHECKSUM_EN
        check("after_rst:sum_ffff", checksum, 32'hFFFFFFFC);
`endif

        for (int t = 0; t < 8; t++) begin
            int unsigned widx, cnt;
            widx = $urandom_range(0, MW - 16);
            cnt  = $urandom_range(1, 12);
            rand_words(cnt);
            run_load($sformatf("rand%0d", t), AW'(widx * 4), cnt, 2, 1, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
